dz_decode: RTL and testbench
============================

# dz_decode

Receive-side decoder for the 8x8 bicolour dot-matrix scan bus. It watches the row-select and red/green column lines driven by the digit display driver and rebuilds each scanned frame in an internal buffer. It then matches the frame against the six digit glyphs (0-5) and reports the decoded digit and colour once per frame. It sits on the board-test/self-check path beside the display driver, on the same clock.

## Interface
- SETTLE, default 2: consecutive cycles a row code must stay stable before its columns are sampled (1..15).
- TIMEOUT, default 4096: cycles without a row capture before a partial frame is discarded (16-bit counter).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- row  input  8  row select, active-low one-hot; row[i]=0 selects row i; row 0 is the top row.
- colr  input  8  red column plane, active-high; bit 7 is the leftmost column.
- colg  input  8  green column plane, same format.
- valid  output  1  one-cycle pulse per completed frame.
- hit  output  1  last frame matched a glyph exactly.
- num  output  3  decoded digit 0-5; 3'd7 when hit=0.
- color  output  2  00 none, 01 green, 10 red, 11 yellow (both planes).
- blank  output  1  last frame was all-zero on both planes.

## Operation
- Row index decode: row has exactly one zero bit -> index = position of that bit. Any other code (8'hFF, multiple zeros) is invalid.
- Dwell counter: reset to 0 on an invalid code or when the code differs from the previous cycle. Otherwise it increments and saturates at SETTLE.
- Capture: on the cycle the counter first reaches SETTLE, write {colr, colg} into frame[index] and set mask[index]. Only one capture per dwell. A re-captured row overwrites its stored entry.
- FSM states: COLLECT, EVAL.
  - COLLECT -> EVAL when mask becomes 8'hFF. The frame is copied to a shadow buffer and mask is cleared in the same edge.
  - EVAL -> COLLECT after exactly one cycle. Captures continue during EVAL into the cleared mask, so no row is lost.
- Match in EVAL: the shadow frame is compared to the glyph table. Row 0 is 00/00 for every glyph. Rows 1..7 are listed below as r / g:
  - Digit 0: r 00 on all rows; g 3C,42,42,42,42,42,3C.
  - Digit 1: r 00 on all rows; g 18,18,38,18,18,18,7E.
  - Digit 2: r = g = 3C,66,06,0C,30,60,7E.
  - Digit 3: r = g = 3C,66,06,1C,06,66,3C.
  - Digit 4: g 00 on all rows; r 0C,1C,2C,4C,7E,0C,0C.
  - Digit 5: g 00 on all rows; r 7E,60,7C,06,06,66,3C.
- A match requires both planes to be identical in all 8 rows. Exactly one glyph can match.
- color is taken from the planes alone: OR of all colr bits is bit1, OR of all colg bits is bit0. This is independent of hit.
- blank = 1 if both planes are zero in all 8 rows. In that case hit=0, num=7, color=00.
- Timeout: the idle counter resets on every capture and increments otherwise. When it reaches TIMEOUT with mask nonzero, mask is cleared. No valid pulse is produced and the counter restarts.

## Timing
- Reset values: valid=0, hit=0, num=3'd7, color=2'b00, blank=0. Also mask=0, dwell=0, idle counter=0, FSM=COLLECT. Frame and shadow buffers are cleared to 0.
- Capture latency: a row code first presented at edge E is captured at edge E+SETTLE (inputs are registered once before decode).
- Frame result latency: the final row is captured at edge C. EVAL occurs in the cycle after C. valid, hit, num, color and blank update together at edge C+2.
- valid is high for exactly one cycle. hit, num, color and blank hold until the next valid.
- Simultaneous capture and timeout: the capture wins, the idle counter resets and mask keeps its bits.
- Reset asserted mid-frame: all state clears immediately. The first frame after release requires all 8 rows again.

## Test plan
- Digit 3 scan: rows 0..7 each held 4 cycles with the digit-3 glyph on both planes -> one valid; hit=1, num=3, color=11, blank=0; valid exactly 2 edges after the row-7 capture.
- Digit 0, then digit 4 back-to-back with no gap -> two valid pulses. First pulse: num=0, color=01. Second pulse: num=4, color=10. No row is lost across EVAL.
- Glitch rejection, SETTLE=2: 1-cycle row pulses interleaved with row=8'h00 and row=8'hFF -> no captures, no valid. A 2-cycle dwell is captured.
- Corrupt glyph: digit-5 frame with the row-3 red plane set to 7D -> valid=1, hit=0, num=7, color=10. All-zero frame -> blank=1, color=00.
- Partial frame: rows 0..5 scanned, then row=FF for TIMEOUT cycles -> mask cleared, no valid. A following full digit-1 frame -> num=1, color=01.
- Reset mid-frame: rst low after 4 rows, released, then 8 rows of digit 2 -> exactly one valid, num=2, color=11. All outputs are at reset values while rst is low.

Source files
------------

// File: rtl/dz_decode.sv
// rtl/dz_decode.sv - scan-bus frame rebuilder and digit glyph matcher
// Captures settled rows into a frame buffer, then classifies each full frame once.
module dz_decode #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] row,
  input  logic [7:0] colr,
  input  logic [7:0] colg,
  output logic       valid,
  output logic       hit,
  output logic [2:0] num,
  output logic [1:0] color,
  output logic       blank
);
  localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {COLLECT, EVAL} state_t;

  // Row 0 occupies the top byte; row i sits at bits [63-8i -: 8].
  function automatic logic [63:0] glyph_r(input int d);
    case (d)
      2:       glyph_r = 64'h003C66060C30607E;
      3:       glyph_r = 64'h003C66061C06663C;
      4:       glyph_r = 64'h000C1C2C4C7E0C0C;
      5:       glyph_r = 64'h007E607C0606663C;
      default: glyph_r = 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] glyph_g(input int d);
    case (d)
      0:       glyph_g = 64'h003C42424242423C;
      1:       glyph_g = 64'h001818381818187E;
      2:       glyph_g = 64'h003C66060C30607E;
      3:       glyph_g = 64'h003C66061C06663C;
      default: glyph_g = 64'h0;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_row_q;
  logic [7:0]  r_row_prev;
  logic [7:0]  r_colr_q;
  logic [7:0]  r_colg_q;
  logic [3:0]  r_dwell;
  logic [7:0]  r_mask;
  logic [15:0] r_idle;
  logic [7:0]  r_frame_r [8];
  logic [7:0]  r_frame_g [8];
  logic [63:0] r_shadow_r;
  logic [63:0] r_shadow_g;
  logic        r_valid;
  logic        r_hit;
  logic [2:0]  r_num;
  logic [1:0]  r_color;
  logic        r_blank;

  logic [7:0]  w_sel;
  logic        w_row_ok;
  logic [2:0]  w_idx;
  logic        w_new;
  logic        w_capture;
  logic [7:0]  w_cap_bit;
  logic        w_start_eval;
  logic [63:0] w_flat_r;
  logic [63:0] w_flat_g;
  logic        w_hit;
  logic [2:0]  w_num;
  logic        w_blank;
  logic [1:0]  w_color;

  always_comb begin
    w_sel    = ~r_row_q;
    w_row_ok = $onehot(w_sel);
    w_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
    w_new = (r_row_q != r_row_prev);
    // A fresh code counts as its first settled cycle; capture fires once, on reaching SETTLE.
    w_capture = w_row_ok && (w_new ? (SETTLE_C == 4'd1) : (r_dwell == SETTLE_C - 4'd1));
    w_cap_bit = w_capture ? (8'h01 << w_idx) : 8'h00;
    w_start_eval = (r_state == COLLECT) && (r_mask == 8'hFF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_q    <= 8'hFF;
      r_row_prev <= 8'hFF;
      r_colr_q   <= 8'h00;
      r_colg_q   <= 8'h00;
    end else begin
      r_row_q    <= row;
      r_row_prev <= r_row_q;
      r_colr_q   <= colr;
      r_colg_q   <= colg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dwell <= 4'd0;
    end else if (!w_row_ok) begin
      r_dwell <= 4'd0;
    end else if (w_new) begin
      r_dwell <= 4'd1;
    end else if (r_dwell != SETTLE_C) begin
      r_dwell <= r_dwell + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_frame_r[i] <= 8'h00;
        r_frame_g[i] <= 8'h00;
      end
    end else if (w_capture) begin
      r_frame_r[w_idx] <= r_colr_q;
      r_frame_g[w_idx] <= r_colg_q;
    end
  end

  always_comb begin
    w_flat_r = 64'h0;
    w_flat_g = 64'h0;
    for (int i = 0; i < 8; i++) begin
      w_flat_r[63-8*i -: 8] = r_frame_r[i];
      w_flat_g[63-8*i -: 8] = r_frame_g[i];
    end
  end

  // Capture outranks both the eval-time clear and the timeout clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask     <= 8'h00;
      r_idle     <= 16'd0;
      r_shadow_r <= 64'h0;
      r_shadow_g <= 64'h0;
    end else begin
      if (w_start_eval) begin
        r_shadow_r <= w_flat_r;
        r_shadow_g <= w_flat_g;
        r_mask     <= w_cap_bit;
      end else if (w_capture) begin
        r_mask <= r_mask | w_cap_bit;
      end else if ((r_idle == IDLE_LAST) && (r_mask != 8'h00)) begin
        r_mask <= 8'h00;
      end

      if (w_capture || (r_idle == IDLE_LAST)) r_idle <= 16'd0;
      else                                    r_idle <= r_idle + 16'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_start_eval) w_state_next = EVAL;
      EVAL:    w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= COLLECT;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_hit = 1'b0;
    w_num = 3'd7;
    for (int d = 0; d < 6; d++) begin
      if ((r_shadow_r == glyph_r(d)) && (r_shadow_g == glyph_g(d))) begin
        w_hit = 1'b1;
        w_num = 3'(d);
      end
    end
    w_color = {|r_shadow_r, |r_shadow_g};
    w_blank = (r_shadow_r == 64'h0) && (r_shadow_g == 64'h0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_num   <= 3'd7;
      r_color <= 2'b00;
      r_blank <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == EVAL) begin
        r_valid <= 1'b1;
        r_hit   <= w_hit;
        r_num   <= w_num;
        r_color <= w_color;
        r_blank <= w_blank;
      end
    end
  end

  assign valid = r_valid;
  assign hit   = r_hit;
  assign num   = r_num;
  assign color = r_color;
  assign blank = r_blank;
endmodule

// File: tb/tb_dz_decode.sv
// tb/tb_dz_decode.sv - scoreboard bench for dz_decode
// Expected frame results are queued as each frame is scanned and popped on valid.
module tb_dz_decode;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] row = 8'hFF;
  logic [7:0] colr = 8'h00;
  logic [7:0] colg = 8'h00;
  logic       valid;
  logic       hit;
  logic [2:0] num;
  logic [1:0] color;
  logic       blank;

  dz_decode #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .row(row), .colr(colr), .colg(colg),
    .valid(valid), .hit(hit), .num(num), .color(color), .blank(blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       hit;
    logic [2:0] num;
    logic [1:0] color;
    logic       blank;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_exp;
  int          n_checks = 0;
  int          n_pass = 0;
  int          valid_count = 0;
  int          last_valid_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] gr[6];
  logic [63:0] gg[6];

  always @(negedge clk) begin
    if (rst && valid) begin
      valid_count++;
      last_valid_cyc = cyc;
      n_checks++;
      if (prev_valid !== 1'b0) $display("FAIL valid_width: valid high %0d cycles in a row, want 1", 2);
      else n_pass++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: valid=1 at cycle %0d, want no frame result pending", cyc);
      end else begin
        n_pass++;
        m_exp = sb.pop_front();
        n_checks++;
        if (hit !== m_exp.hit) $display("FAIL sb_hit: got %0b want %0b", hit, m_exp.hit);
        else n_pass++;
        n_checks++;
        if (num !== m_exp.num) $display("FAIL sb_num: got %0d want %0d", num, m_exp.num);
        else n_pass++;
        n_checks++;
        if (color !== m_exp.color) $display("FAIL sb_color: got %b want %b", color, m_exp.color);
        else n_pass++;
        n_checks++;
        if (blank !== m_exp.blank) $display("FAIL sb_blank: got %0b want %0b", blank, m_exp.blank);
        else n_pass++;
      end
    end
    prev_valid = valid;
  end

  task automatic put_row(input int i, input logic [7:0] r, input logic [7:0] g, input int hold,
                         output int e);
    logic [7:0] one;
    one = 8'h01;
    @(negedge clk);
    row  = ~(one << i);
    colr = r;
    colg = g;
    e    = cyc + 1;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [63:0] fr, input logic [63:0] fg, input int first, input int last,
                      input int hold, output int e_last);
    for (int i = first; i <= last; i++) put_row(i, fr[63-8*i -: 8], fg[63-8*i -: 8], hold, e_last);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    row  = 8'hFF;
    colr = 8'h00;
    colg = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({valid, hit, num, color, blank} !== 8'h38)
      $display("FAIL reset_outputs: got %h want 38", {valid, hit, num, color, blank});
    else n_pass++;
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_digit3();
    int base, e7;
    base = valid_count;
    sb.push_back('{1'b1, 3'd3, 2'b11, 1'b0});
    scan(gr[3], gg[3], 0, 7, 4, e7);
    idle(12);
    n_checks++;
    if (valid_count !== base + 1) $display("FAIL d3_count: got %0d want %0d", valid_count, base + 1);
    else n_pass++;
    n_checks++;
    if (last_valid_cyc !== e7 + SETTLE + 2)
      $display("FAIL d3_latency: got cycle %0d want %0d", last_valid_cyc, e7 + SETTLE + 2);
    else n_pass++;
    n_checks++;
    if ({hit, num} !== 4'b1011) $display("FAIL d3_hold: got %h want b", {hit, num});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base, e;
    base = valid_count;
    sb.push_back('{1'b1, 3'd0, 2'b01, 1'b0});
    sb.push_back('{1'b1, 3'd4, 2'b10, 1'b0});
    scan(gr[0], gg[0], 0, 7, 4, e);
    scan(gr[4], gg[4], 0, 7, 4, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 2) $display("FAIL b2b_count: got %0d want %0d", valid_count, base + 2);
    else n_pass++;
    n_checks++;
    if (last_valid_cyc !== e + SETTLE + 2)
      $display("FAIL b2b_latency: got cycle %0d want %0d", last_valid_cyc, e + SETTLE + 2);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int base, e;
    base = valid_count;
    for (int i = 0; i < 8; i++) begin
      put_row(i, gr[1][63-8*i -: 8], gg[1][63-8*i -: 8], 1, e);
      @(negedge clk);
      row = 8'h00;
      put_row((i + 3) % 8, 8'hFF, 8'hFF, 1, e);
      put_row((i + 5) % 8, 8'hAA, 8'h55, 1, e);
      @(negedge clk);
      row = 8'hFF;
    end
    idle(12);
    n_checks++;
    if (valid_count !== base) $display("FAIL glitch_count: got %0d want %0d", valid_count, base);
    else n_pass++;
    sb.push_back('{1'b1, 3'd2, 2'b11, 1'b0});
    scan(gr[2], gg[2], 0, 7, SETTLE, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 1) $display("FAIL dwell2_count: got %0d want %0d", valid_count, base + 1);
    else n_pass++;
    n_checks++;
    if (last_valid_cyc !== e + SETTLE + 2)
      $display("FAIL dwell2_latency: got cycle %0d want %0d", last_valid_cyc, e + SETTLE + 2);
    else n_pass++;
  endtask

  task automatic test_corrupt();
    int base, e;
    logic [63:0] fr;
    base = valid_count;
    fr = gr[5];
    fr[63-24 -: 8] = 8'h7D;
    sb.push_back('{1'b0, 3'd7, 2'b10, 1'b0});
    scan(fr, gg[5], 0, 7, 4, e);
    sb.push_back('{1'b0, 3'd7, 2'b00, 1'b1});
    scan(64'h0, 64'h0, 0, 7, 4, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 2) $display("FAIL corrupt_count: got %0d want %0d", valid_count, base + 2);
    else n_pass++;
  endtask

  task automatic test_partial();
    int base, e;
    base = valid_count;
    sb.push_back('{1'b1, 3'd1, 2'b01, 1'b0});
    scan(gr[1], gg[1], 0, 5, 4, e);
    idle(TIMEOUT - 40);
    scan(gr[1], gg[1], 6, 7, 4, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 1) $display("FAIL pre_timeout_count: got %0d want %0d", valid_count, base + 1);
    else n_pass++;
    scan(gr[3], gg[3], 0, 5, 4, e);
    idle(TIMEOUT + 10);
    scan(gr[1], gg[1], 6, 7, 4, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 1) $display("FAIL timeout_count: got %0d want %0d", valid_count, base + 1);
    else n_pass++;
    idle(TIMEOUT + 10);
    sb.push_back('{1'b1, 3'd1, 2'b01, 1'b0});
    scan(gr[1], gg[1], 0, 7, 4, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 2) $display("FAIL after_timeout_count: got %0d want %0d", valid_count, base + 2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base, e;
    base = valid_count;
    scan(gr[5], gg[5], 4, 7, 4, e);
    @(negedge clk);
    rst = 1'b0;
    row = 8'hFF;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({valid, hit, num, color, blank} !== 8'h38)
      $display("FAIL midreset_outputs: got %h want 38", {valid, hit, num, color, blank});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{1'b1, 3'd2, 2'b11, 1'b0});
    scan(gr[2], gg[2], 0, 7, 4, e);
    idle(12);
    n_checks++;
    if (valid_count !== base + 1) $display("FAIL midreset_count: got %0d want %0d", valid_count, base + 1);
    else n_pass++;
  endtask

  initial begin
    gr[0] = 64'h0;                gg[0] = 64'h003C42424242423C;
    gr[1] = 64'h0;                gg[1] = 64'h001818381818187E;
    gr[2] = 64'h003C66060C30607E; gg[2] = 64'h003C66060C30607E;
    gr[3] = 64'h003C66061C06663C; gg[3] = 64'h003C66061C06663C;
    gr[4] = 64'h000C1C2C4C7E0C0C; gg[4] = 64'h0;
    gr[5] = 64'h007E607C0606663C; gg[5] = 64'h0;
    test_reset();
    test_digit3();
    test_back_to_back();
    test_glitch();
    test_corrupt();
    test_partial();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
